// File: rtl/dtmf_tone_gen.sv
// DTMF generator: row/column square waves for one key, then a silent gap and a done pulse.
// Optional macro DTMF_PENDING_EN adds a one-entry pending key so keys can be played back to back.
module dtmf_tone_gen #(
  parameter int CLK_HZ  = 1000000,
  parameter int CNT_W   = 10,
  parameter int TONE_MS = 100,
  parameter int GAP_MS  = 50
) (
  input  logic       inclk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       row_clk,
  output logic       col_clk,
  output logic       tone_active,
  output logic       done
);

  // Terminal count of a half-period divider: round(CLK_HZ/(2f)) - 1.
  function automatic logic [CNT_W-1:0] lastOf(input int freq);
    return CNT_W'((CLK_HZ + freq) / (2 * freq) - 1);
  endfunction

  localparam logic [CNT_W-1:0] ROW_LAST0 = lastOf(697);
  localparam logic [CNT_W-1:0] ROW_LAST1 = lastOf(770);
  localparam logic [CNT_W-1:0] ROW_LAST2 = lastOf(852);
  localparam logic [CNT_W-1:0] ROW_LAST3 = lastOf(941);
  localparam logic [CNT_W-1:0] COL_LAST0 = lastOf(1209);
  localparam logic [CNT_W-1:0] COL_LAST1 = lastOf(1336);
  localparam logic [CNT_W-1:0] COL_LAST2 = lastOf(1477);
  localparam logic [CNT_W-1:0] COL_LAST3 = lastOf(1633);

  localparam int MS_DIV    = CLK_HZ / 1000;
  localparam int TICK_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int MS_MAX    = (TONE_MS > GAP_MS) ? TONE_MS : GAP_MS;
  localparam int MS_W      = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int TONE_LAST = (TONE_MS > 0) ? TONE_MS - 1 : 0;
  localparam int GAP_LAST  = (GAP_MS > 0) ? GAP_MS - 1 : 0;
  localparam bit TONE_ZERO = (TONE_MS == 0);
  localparam bit GAP_ZERO  = (GAP_MS == 0);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]   TONE_LAST_V = MS_W'(TONE_LAST);
  localparam logic [MS_W-1:0]   GAP_LAST_V  = MS_W'(GAP_LAST);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_key;
  logic [TICK_W-1:0] r_tickCnt;
  logic [MS_W-1:0]   r_msCnt;
  logic [CNT_W-1:0]  r_rowCnt;
  logic [CNT_W-1:0]  r_colCnt;
  logic              r_rowClk;
  logic              r_colClk;
  logic              r_done;
  logic              w_accept;
  logic              w_msTick;
  logic              w_zeroLen;
  logic [MS_W-1:0]   w_phaseLast;
  logic              w_phaseEnd;
  logic [CNT_W-1:0]  w_rowLast;
  logic [CNT_W-1:0]  w_colLast;
`ifdef DTMF_PENDING_EN
  logic [3:0]        r_pendKey;
  logic              r_pendValid;
`endif

  assign row_clk  = r_rowClk;
  assign col_clk  = r_colClk;
  assign done     = r_done;
  assign w_accept = key_valid && key_ready;
  assign w_msTick = (r_tickCnt == TICK_LAST);

  // A phase ends on the ms tick closing its last millisecond; zero-length phases last one cycle.
  always_comb begin
    w_zeroLen   = TONE_ZERO;
    w_phaseLast = TONE_LAST_V;
    if (r_state == GAP) begin
      w_zeroLen   = GAP_ZERO;
      w_phaseLast = GAP_LAST_V;
    end
    w_phaseEnd = (r_state != IDLE) && (w_zeroLen || (w_msTick && (r_msCnt == w_phaseLast)));
  end

  always_comb begin
    w_rowLast = ROW_LAST0;
    w_colLast = COL_LAST0;
    case (r_key[3:2])
      2'd1:    w_rowLast = ROW_LAST1;
      2'd2:    w_rowLast = ROW_LAST2;
      2'd3:    w_rowLast = ROW_LAST3;
      default: w_rowLast = ROW_LAST0;
    endcase
    case (r_key[1:0])
      2'd1:    w_colLast = COL_LAST1;
      2'd2:    w_colLast = COL_LAST2;
      2'd3:    w_colLast = COL_LAST3;
      default: w_colLast = COL_LAST0;
    endcase
  end

  always_ff @(posedge inclk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    tone_active = (r_state == TONE);
`ifdef DTMF_PENDING_EN
    key_ready   = !r_pendValid;
`else
    key_ready   = (r_state == IDLE);
`endif
    case (r_state)
      IDLE: if (w_accept) w_next = TONE;
      TONE: if (w_phaseEnd) w_next = GAP;
      GAP: begin
        if (w_phaseEnd) begin
          w_next = IDLE;
`ifdef DTMF_PENDING_EN
          if (r_pendValid || w_accept) w_next = TONE;
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Key capture; with the pending option a key offered during TONE/GAP is parked until GAP ends.
  always_ff @(posedge inclk) begin
    if (rst) begin
      r_key <= 4'd0;
`ifdef DTMF_PENDING_EN
      r_pendKey   <= 4'd0;
      r_pendValid <= 1'b0;
`endif
    end else if (r_state == IDLE) begin
      if (w_accept) r_key <= key_code;
`ifdef DTMF_PENDING_EN
    end else if ((r_state == GAP) && w_phaseEnd) begin
      if (r_pendValid) begin
        r_key       <= r_pendKey;
        r_pendValid <= 1'b0;
      end else if (w_accept) begin
        r_key <= key_code;
      end
    end else if (w_accept) begin
      r_pendKey   <= key_code;
      r_pendValid <= 1'b1;
`endif
    end
  end

  always_ff @(posedge inclk) begin
    if (rst || (r_state == IDLE) || w_phaseEnd) begin
      r_tickCnt <= '0;
      r_msCnt   <= '0;
    end else if (w_msTick) begin
      r_tickCnt <= '0;
      r_msCnt   <= r_msCnt + 1'b1;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  // Dividers run only inside TONE and are cleared on the way out so every tone starts low.
  always_ff @(posedge inclk) begin
    if (rst || (r_state != TONE) || w_phaseEnd) begin
      r_rowCnt <= '0;
      r_colCnt <= '0;
      r_rowClk <= 1'b0;
      r_colClk <= 1'b0;
    end else begin
      if (r_rowCnt == w_rowLast) begin
        r_rowCnt <= '0;
        r_rowClk <= !r_rowClk;
      end else begin
        r_rowCnt <= r_rowCnt + 1'b1;
      end
      if (r_colCnt == w_colLast) begin
        r_colCnt <= '0;
        r_colClk <= !r_colClk;
      end else begin
        r_colCnt <= r_colCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge inclk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == GAP) && w_phaseEnd;
  end

endmodule

// File: doc/dtmf_tone_gen.md
DTMF_TONE_GEN -- requirements
Module: dtmf_tone_gen

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 1000000, meaning the inclk frequency in Hz.
REQ-002 The module SHALL have parameter CNT_W, default 10, meaning the divider counter width; it must hold the largest half-period divisor.
REQ-003 The module SHALL have parameter TONE_MS, default 100, meaning the tone-on duration in milliseconds.
REQ-004 The module SHALL have parameter GAP_MS, default 50, meaning the silent gap after each tone in milliseconds.
REQ-005 The module SHALL use one clock, inclk; reset rst is synchronous and active-high.
REQ-006 Port list: inclk  in  1  clock; rst  in  1  sync active-high reset; key_valid  in  1  key offer; key_code  in  4  key index; key_ready  out  1  key accept; row_clk  out  1  row tone square wave; col_clk  out  1  column tone square wave; tone_active  out  1  tone playing; done  out  1  one-cycle completion pulse.

Function
REQ-007 Key mapping SHALL be key_code[3:2] = row (697/770/852/941 Hz) and key_code[1:0] = column (1209/1336/1477/1633 Hz).
REQ-008 Each half-period divisor SHALL be round(CLK_HZ/(2*f)), computed at elaboration.
REQ-009 With CLK_HZ=1e6, the row divisors SHALL be 717/649/587/531 and the column divisors SHALL be 414/374/339/306.
REQ-010 The FSM SHALL have exactly three states: IDLE, TONE, GAP.
REQ-011 In IDLE, key_ready SHALL be 1.
REQ-012 When key_valid=1 and key_ready=1 on a rising edge, key_code SHALL be captured and the FSM SHALL move to TONE on the next cycle.
REQ-013 key_valid SHALL be ignored whenever key_ready=0.
REQ-014 On entry to TONE, both divider counters and the ms counter SHALL be 0, and row_clk and col_clk SHALL be 0.
REQ-015 In TONE, each divider SHALL increment per cycle; at count == DIV-1 it SHALL toggle its output and reset to 0, giving exactly DIV cycles per half-period.
REQ-016 The ms tick SHALL fire every CLK_HZ/1000 cycles.
REQ-017 TONE SHALL last exactly TONE_MS*CLK_HZ/1000 cycles, with tone_active=1 throughout, then the FSM SHALL move to GAP.
REQ-018 In GAP, row_clk=col_clk=0, tone_active=0, and divider counters SHALL be held at 0.
REQ-019 GAP SHALL last exactly GAP_MS*CLK_HZ/1000 cycles, then the FSM SHALL move to IDLE.
REQ-020 done SHALL pulse 1 for exactly one cycle, the first cycle after GAP ends.
REQ-021 Divider and ms counters SHALL wrap only via their explicit terminal compare, never by overflow.
REQ-022 If TONE_MS=0, TONE SHALL last 1 cycle; if GAP_MS=0, GAP SHALL last 1 cycle.
REQ-023 A key_valid held high across done SHALL be accepted in the first IDLE cycle.

Reset
REQ-024 On rst=1 at a rising edge, the state SHALL be IDLE and all counters 0.
REQ-025 Reset values SHALL be: row_clk=0, col_clk=0, tone_active=0, done=0, key_ready=1 (from the first cycle after reset).
REQ-026 Reset mid-TONE or mid-GAP SHALL abort immediately, with no done pulse and any pending key discarded.

Configuration
REQ-027 Macro DTMF_PENDING_EN, when defined, SHALL add a one-entry pending register.
REQ-028 With DTMF_PENDING_EN, key_ready SHALL be 1 in TONE/GAP while the pending register is empty.
REQ-029 With DTMF_PENDING_EN, a key accepted there SHALL be held, and the FSM SHALL go from GAP directly to TONE with that key (no IDLE cycle); done still pulses for the finished key.
REQ-030 With DTMF_PENDING_EN, if a key is pending, a simultaneous IDLE-style accept SHALL not occur; key_ready stays 0 until the pending key enters TONE.
REQ-031 Without DTMF_PENDING_EN, key_ready SHALL be 0 outside IDLE and there SHALL be no pending register.

Verification
REQ-032 Defaults, accept key_code=0x5: first row_clk rise 649 cycles after TONE entry, first col_clk rise 374 cycles after; tone_active high 100000 cycles.
REQ-033 Defaults, key_code=0xF: row_clk period 1062 cycles, col_clk period 612 cycles; done pulses once, 150000 cycles after TONE entry.
REQ-034 TONE_MS=2, GAP_MS=1, key 0x0, rst at cycle 1000 of TONE: next cycle all outputs at reset values, key_ready=1, no done.
REQ-035 Without macro, TONE_MS=2: key_valid=1 with code 0x3 during TONE: not accepted, single tone played, one done.
REQ-036 With DTMF_PENDING_EN, TONE_MS=2, GAP_MS=1: second key 0xC accepted during TONE; TONE(0xC) starts the cycle after GAP ends; two done pulses 3000 cycles apart.
